// File: rtl/sound_i2s_pkg.sv
// Shared constants and helpers for the I2S sound output block.
package sound_i2s_pkg;

   localparam int VOL_MAX  = 256;
   localparam int VOL_BITS = 9;

   // Arithmetic left shift of a signed value, clamped to the signed range of
   // 'width' bits. The result is returned sign-extended to 32 bits.
   function automatic logic signed [31:0] sat_shift(input logic signed [31:0] value,
                                                    input int shift,
                                                    input int width);
      logic signed [63:0] wide;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      wide  = 64'(value) <<< shift;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (wide > max_v)
         sat_shift = max_v[31:0];
      else if (wide < min_v)
         sat_shift = min_v[31:0];
      else
         sat_shift = wide[31:0];
   endfunction

endpackage

// File: rtl/sound_i2s_gain.sv
// Combinational gain stage: saturating fixed shift, then volume scaling
// with vol = 256 as unity.
module sound_i2s_gain
   import sound_i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int GAIN_SHIFT   = 0
) (
   input  logic signed [SAMPLE_WIDTH-1:0] sound_in,
   input  logic        [VOL_BITS-1:0]     vol,
   output logic signed [SAMPLE_WIDTH-1:0] sample
);

   localparam int PROD_W = SAMPLE_WIDTH + 10;

   logic signed [31:0]       sat_wide;
   logic signed [PROD_W-1:0] s_ext;
   logic signed [PROD_W-1:0] vol_ext;
   logic signed [PROD_W-1:0] product;

   // Saturate, multiply by the unsigned volume, floor-divide by 256.
   always_comb begin
      sat_wide = sat_shift(32'(sound_in), GAIN_SHIFT, SAMPLE_WIDTH);
      s_ext    = PROD_W'(sat_wide);
      vol_ext  = PROD_W'($signed({1'b0, vol}));
      product  = s_ext * vol_ext;
      sample   = SAMPLE_WIDTH'(product >>> 8);
   end

endmodule

// File: rtl/sound_i2s_out.sv
// Philips I2S serialiser for the external sound mix: derives BCLK/LRCK from
// CLK, latches one gained sample per frame and sends it on both channels,
// with a per-frame soft-mute volume ramp.
module sound_i2s_out
   import sound_i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SLOT_WIDTH   = 32,
   parameter int BCLK_DIV     = 4,
   parameter int GAIN_SHIFT   = 0,
   parameter int VOL_STEP     = 4
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic signed [SAMPLE_WIDTH-1:0] SOUND_IN,
   input  logic                           MUTE,
   output logic                           I2S_BCLK,
   output logic                           I2S_LRCK,
   output logic                           I2S_SDATA,
   output logic                           FRAME_STROBE
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
   localparam int IDX_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
   localparam logic [BIT_W-1:0]    SLOT_LEN = BIT_W'(SLOT_WIDTH);
   localparam logic [BIT_W-1:0]    POS_MAX  = BIT_W'(SAMPLE_WIDTH);
   localparam logic [VOL_BITS-1:0] VOL_FULL = VOL_BITS'(VOL_MAX);
   localparam logic [VOL_BITS-1:0] VOL_INC  = VOL_BITS'(VOL_STEP);

   logic [DIV_W-1:0]              div_cnt;
   logic [BIT_W-1:0]              bit_cnt;
   logic [BIT_W-1:0]              bit_nxt;
   logic [BIT_W-1:0]              pos_nxt;
   logic [IDX_W-1:0]              bit_idx;
   logic signed [SAMPLE_WIDTH-1:0] hold;
   logic signed [SAMPLE_WIDTH-1:0] gained;
   logic [VOL_BITS-1:0]           vol;
   logic [VOL_BITS-1:0]           vol_nxt;
   logic                          fall_event;
   logic                          frame_start;
   logic                          sdata_nxt;

   sound_i2s_gain #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .GAIN_SHIFT   (GAIN_SHIFT)
   ) u_gain (
      .sound_in (SOUND_IN),
      .vol      (vol),
      .sample   (gained)
   );

   // Next bit position, serial data bit for it, and next ramp volume.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      sdata_nxt   = 1'b0;
      bit_idx     = '0;
      fall_event  = (div_cnt == DIV_LAST) && I2S_BCLK;
      bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      frame_start = fall_event && (bit_cnt == BIT_LAST);
      pos_nxt     = (bit_nxt >= SLOT_LEN) ? bit_nxt - SLOT_LEN : bit_nxt;
      // Position 0 is the I2S one-bit delay; the sample follows MSB first.
      if ((pos_nxt != '0) && (pos_nxt <= POS_MAX)) begin
         bit_idx   = IDX_W'(POS_MAX - pos_nxt);
         sdata_nxt = hold[bit_idx];
      end
      if (MUTE)
         vol_nxt = (vol > VOL_INC) ? vol - VOL_INC : '0;
      else
         vol_nxt = (vol >= VOL_FULL - VOL_INC) ? VOL_FULL : vol + VOL_INC;
   end

   // Prescaler, bit counter, frame latch and registered I2S outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_cnt      <= '0;
         bit_cnt      <= BIT_LAST;
         hold         <= '0;
         vol          <= VOL_FULL;
         I2S_BCLK     <= 1'b0;
         I2S_LRCK     <= 1'b0;
         I2S_SDATA    <= 1'b0;
         FRAME_STROBE <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         FRAME_STROBE <= frame_start;
         if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            I2S_BCLK <= ~I2S_BCLK;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (fall_event) begin
            bit_cnt   <= bit_nxt;
            I2S_LRCK  <= (bit_nxt >= SLOT_LEN);
            I2S_SDATA <= sdata_nxt;
            if (frame_start) begin
               hold <= gained;
               vol  <= vol_nxt;
            end
         end
      end
   end

endmodule
